fb_scanout_ctrl: RTL and testbench



---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_flip_reg.sv | 35 +++
 rtl/fb_scanout_ctrl.sv | 141 ++++++++++++++
 tb/tb_fb_scanout_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the framebuffer scan-out sequencer.
package fb_pkg;

  localparam int unsigned FRAME_PIX  = 384000;
  localparam int unsigned BURST_LEN  = 32;
  localparam int unsigned FIFO_DEPTH = 64;
  localparam int unsigned FIFO_AW    = 6;
  localparam int unsigned ADDR_W     = 26;
  localparam int unsigned PIX_BYTES  = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    ISSUE,
    DRAIN
  } fb_state_e;

endpackage

// File: rtl/fb_flip_reg.sv
// Pending page-flip register: last request wins; a request coinciding with
// an apply survives that apply and stays pending.
module fb_flip_reg
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W = fb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flip_req_i,
  input  logic [ADDR_W-1:0] flip_base_i,
  input  logic              apply_i,
  output logic              pending_o,
  output logic [ADDR_W-1:0] pending_base_o
);

  logic              pending_q;
  logic [ADDR_W-1:0] base_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      base_q    <= '0;
    end else if (flip_req_i) begin
      pending_q <= 1'b1;
      base_q    <= flip_base_i & ~ADDR_W'(1);
    end else if (apply_i) begin
      pending_q <= 1'b0;
    end
  end

  assign pending_o      = pending_q;
  assign pending_base_o = base_q;

endmodule

// File: rtl/fb_scanout_ctrl.sv
// Read-side framebuffer sequencer: fetches a frame as bursts of single-word
// reads paced by FIFO free space, and applies page flips at frame boundaries.
module fb_scanout_ctrl
  import fb_pkg::*;
#(
  parameter int unsigned FRAME_PIX  = fb_pkg::FRAME_PIX,
  parameter int unsigned BURST_LEN  = fb_pkg::BURST_LEN,
  parameter int unsigned FIFO_DEPTH = fb_pkg::FIFO_DEPTH,
  parameter int unsigned FIFO_AW    = fb_pkg::FIFO_AW,
  parameter int unsigned ADDR_W     = fb_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [ADDR_W-1:0]  flip_base,
  input  logic               flip_req,
  output logic               flip_pending,
  output logic [ADDR_W-1:0]  cur_base,
  output logic               frame_start,
  input  logic [FIFO_AW-1:0] fifo_wrusedw,
  output logic               fifo_wrreq,
  output logic [15:0]        fifo_data,
  output logic [ADDR_W-1:0]  m_address,
  output logic               m_read,
  input  logic               m_waitrequest,
  input  logic               m_readdatavalid,
  input  logic [15:0]        m_readdata
);

  localparam int unsigned OUT_W = FIFO_AW + 1;
  localparam int unsigned RUN_W = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(PIX_BYTES * (FRAME_PIX - 1));
  localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(BURST_LEN - 1);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [ADDR_W-1:0] cur_base_q, cur_base_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic              fifo_wrreq_q;
  logic [15:0]       fifo_data_q;

  logic              accept, ret_ok, apply, space_ok, pend;
  logic [ADDR_W-1:0] pend_base;
  logic [OUT_W:0]    used_sum;

  fb_flip_reg #(.ADDR_W(ADDR_W)) u_flip (
    .clk            (clk),
    .rst            (rst),
    .flip_req_i     (flip_req),
    .flip_base_i    (flip_base),
    .apply_i        (apply),
    .pending_o      (pend),
    .pending_base_o (pend_base)
  );

  assign used_sum = (OUT_W+1)'(fifo_wrusedw) + (OUT_W+1)'(outstanding_q);
  assign space_ok = (32'(used_sum) + BURST_LEN) <= FIFO_DEPTH;
  assign accept   = (state_q == ISSUE) && !m_waitrequest;
  // Returns with nothing in flight belong to reads issued before a reset.
  assign ret_ok   = m_readdatavalid && (outstanding_q != '0);

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    run_d      = run_q;
    cur_base_d = cur_base_q;
    apply      = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          apply    = 1'b1;
          offset_d = '0;
          state_d  = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (space_ok) begin
          run_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          offset_d = offset_q + ADDR_W'(PIX_BYTES);
          run_d    = run_q + RUN_W'(1);
          if (offset_q == LAST_OFF)    state_d = DRAIN;
          else if (run_q == RUN_LAST)  state_d = WAIT_SPACE;
        end
      end
      DRAIN: begin
        if (outstanding_q == '0) begin
          if (enable) begin
            apply    = 1'b1;
            offset_d = '0;
            state_d  = WAIT_SPACE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (apply && pend) cur_base_d = pend_base;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !ret_ok)      outstanding_d = outstanding_q + OUT_W'(1);
    else if (!accept && ret_ok) outstanding_d = outstanding_q - OUT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      offset_q      <= '0;
      cur_base_q    <= '0;
      run_q         <= '0;
      outstanding_q <= '0;
      fifo_wrreq_q  <= 1'b0;
      fifo_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      offset_q      <= offset_d;
      cur_base_q    <= cur_base_d;
      run_q         <= run_d;
      outstanding_q <= outstanding_d;
      fifo_wrreq_q  <= ret_ok;
      fifo_data_q   <= m_readdata;
    end
  end

  assign m_read       = (state_q == ISSUE);
  assign m_address    = cur_base_q + offset_q;
  assign frame_start  = accept && (offset_q == '0);
  assign fifo_wrreq   = fifo_wrreq_q && !rst;
  assign fifo_data    = fifo_data_q;
  assign cur_base     = cur_base_q;
  assign flip_pending = pend;

endmodule

// File: tb/tb_fb_scanout_ctrl.sv
// Scoreboard bench for fb_scanout_ctrl with a 64-pixel frame and a
// fixed-latency slave model; expected reads/pixels are queued per frame.
module tb_fb_scanout_ctrl;

  localparam int unsigned AW     = 26;
  localparam int unsigned TFRAME = 64;

  logic          clk = 1'b0;
  logic          rst, enable, flip_req, flip_pending, frame_start;
  logic [AW-1:0] flip_base, cur_base, m_address;
  logic [5:0]    fifo_wrusedw;
  logic          fifo_wrreq, m_read, m_waitrequest;
  logic [15:0]   fifo_data;
  logic          m_readdatavalid = 1'b0;
  logic [15:0]   m_readdata = '0;

  always #5 clk = ~clk;

  fb_scanout_ctrl #(.FRAME_PIX(TFRAME)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .flip_base       (flip_base),
    .flip_req        (flip_req),
    .flip_pending    (flip_pending),
    .cur_base        (cur_base),
    .frame_start     (frame_start),
    .fifo_wrusedw    (fifo_wrusedw),
    .fifo_wrreq      (fifo_wrreq),
    .fifo_data       (fifo_data),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_waitrequest   (m_waitrequest),
    .m_readdatavalid (m_readdatavalid),
    .m_readdata      (m_readdata)
  );

  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [15:0]   exp_data_q[$];
  int            lat = 3;
  logic [7:0]    pv = '0;
  logic [AW-1:0] pa [8];
  int unsigned   fs_cnt = 0;
  logic [AW-1:0] last_acc = '0;
  logic          mon_acc;

  function automatic logic [15:0] pix_of(input logic [AW-1:0] a);
    return a[16:1] ^ a[25:10] ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [AW-1:0] base);
    logic [AW-1:0] a;
    for (int i = 0; i < int'(TFRAME); i++) begin
      a = base + AW'(2 * i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(pix_of(a));
    end
  endtask

  task automatic wait_mread(input logic lvl, input string name);
    int n = 0;
    @(negedge clk);
    while (m_read !== lvl && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(m_read), 32'(lvl));
  endtask

  task automatic wait_base(input logic [AW-1:0] b, input string name);
    int n = 0;
    @(negedge clk);
    while (cur_base !== b && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(cur_base), 32'(b));
  endtask

  // Slave model and monitor share one process so accept sampling and the
  // return pipeline advance in a fixed order each cycle.
  always begin
    @(negedge clk);
    #1;
    m_readdatavalid = pv[lat-1];
    m_readdata      = pix_of(pa[lat-1]);
    mon_acc = m_read && !m_waitrequest && !rst;
    for (int i = 7; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = mon_acc;
    pa[0] = m_address;
    if (mon_acc) begin
      if (exp_addr_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL read addr: got 0x%0h, expected no read", m_address);
      end else begin
        check("read addr", 32'(m_address), 32'(exp_addr_q.pop_front()));
      end
      last_acc = m_address;
    end
    if (frame_start && !rst) fs_cnt++;
    if (fifo_wrreq) begin
      if (exp_data_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL fifo push: got 0x%0h, expected no push", fifo_data);
      end else begin
        check("fifo data", 32'(fifo_data), 32'(exp_data_q.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  initial begin
    int n, acc_n, run_len, hold_cnt;
    logic [AW-1:0] hold_addr;
    rst = 1'b1; enable = 1'b0; flip_req = 1'b0; flip_base = '0;
    fifo_wrusedw = '0; m_waitrequest = 1'b0;
    repeat (5) @(negedge clk);
    check("rst m_read", 32'(m_read), 0);
    check("rst m_address", 32'(m_address), 0);
    check("rst fifo_wrreq", 32'(fifo_wrreq), 0);
    check("rst frame_start", 32'(frame_start), 0);
    check("rst flip_pending", 32'(flip_pending), 0);
    check("rst cur_base", 32'(cur_base), 0);

    rst = 1'b0;
    push_frame(26'h0);
    enable = 1'b1;

    wait_mread(1'b1, "run1 start");
    run_len = 0;
    while (m_read && run_len < 100) begin
      run_len++;
      @(negedge clk);
    end
    check("run1 length", 32'(run_len), 32);

    wait_mread(1'b1, "run2 start");
    repeat (3) @(negedge clk);
    m_waitrequest = 1'b1;
    hold_addr = m_address;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall addr", 32'(m_address), 32'(hold_addr));
      check("stall read", 32'(m_read), 1);
    end
    m_waitrequest = 1'b0;

    @(negedge clk);
    flip_base = 26'h100000; flip_req = 1'b1;
    push_frame(26'h100000);
    @(negedge clk);
    flip_req = 1'b0;
    check("flip pending set", 32'(flip_pending), 1);
    check("base held mid-frame", 32'(cur_base), 0);
    wait_base(26'h100000, "frame2 base");
    check("flip pending cleared", 32'(flip_pending), 0);
    check("frame1 last addr", 32'(last_acc), 126);

    wait_mread(1'b1, "frame2 start");
    @(negedge clk);
    flip_base = 26'h200000; flip_req = 1'b1;
    @(negedge clk);
    flip_req = 1'b0;
    repeat (8) @(negedge clk);
    flip_base = 26'h300001; flip_req = 1'b1;
    push_frame(26'h300000);
    @(negedge clk);
    flip_req = 1'b0;
    check("frame2 base held", 32'(cur_base), 32'h100000);
    check("frame2 flip pending", 32'(flip_pending), 1);
    n = 0;
    while (!(m_read && !m_waitrequest && m_address == 26'h10007E) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("frame2 last read", 32'(m_address), 32'h10007E);
    // Last return lands 3 cycles after the final accept; the boundary is the cycle after.
    repeat (4) @(negedge clk);
    flip_base = 26'h400000; flip_req = 1'b1;
    push_frame(26'h400000);
    @(negedge clk);
    flip_req = 1'b0;
    check("collision base", 32'(cur_base), 32'h300000);
    check("collision pending", 32'(flip_pending), 1);

    wait_mread(1'b1, "frame3 start");
    fifo_wrusedw = 6'd40;
    wait_mread(1'b0, "frame3 run1 end");
    repeat (4) @(negedge clk);
    hold_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (!m_read) hold_cnt++;
      @(negedge clk);
    end
    check("backpressure hold", 32'(hold_cnt), 8);
    fifo_wrusedw = 6'd32;
    @(negedge clk);
    check("resume at level 32", 32'(m_read), 1);
    fifo_wrusedw = '0;

    wait_base(26'h400000, "frame4 base");
    check("frame4 pending cleared", 32'(flip_pending), 0);
    lat = 6;
    n = 0; acc_n = 0;
    while (acc_n < 5 && n < 300) begin
      @(negedge clk);
      n++;
      if (m_read && !m_waitrequest) acc_n++;
    end
    check("reads before reset", 32'(acc_n), 5);
    @(negedge clk);
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    check("reset m_read", 32'(m_read), 0);
    check("reset fifo_wrreq", 32'(fifo_wrreq), 0);
    check("reset cur_base", 32'(cur_base), 0);
    rst = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (12) @(negedge clk);
    lat = 3;
    push_frame(26'h0);
    enable = 1'b1;
    wait_mread(1'b1, "restart");
    check("restart addr", 32'(m_address), 0);
    enable = 1'b0;

    n = 0;
    while ((exp_addr_q.size() != 0 || exp_data_q.size() != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("frame drained", 32'(exp_addr_q.size() + exp_data_q.size()), 0);
    hold_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!m_read) hold_cnt++;
    end
    check("idle after disable", 32'(hold_cnt), 10);
    check("frame_start count", 32'(fs_cnt), 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
